// File: rtl/deco_3a8_seq.sv
// Sequenced 3-to-8 one-hot decoder with break-before-make gap and optional
// autonomous 0..7 scan mode.
module deco_3a8_seq #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] code_in,
    input  logic       code_valid,
    output logic       code_ready,
    input  logic       scan_en,
    output logic [7:0] y,
    output logic       active,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] code_q, code_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] ptr_q, ptr_d;
    logic       scan_src_q, scan_src_d;
    logic [7:0] y_q, y_d;
    logic       active_q, active_d;
    logic       done_q, done_d;

    always_comb code_ready = (state_q == IDLE) & ~scan_en & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            code_q     <= '0;
            cnt_q      <= '0;
            ptr_q      <= '0;
            scan_src_q <= 1'b0;
            y_q        <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            scan_src_q <= scan_src_d;
            y_q        <= y_d;
            active_q   <= active_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        code_d     = code_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        scan_src_d = scan_src_q;
        unique case (state_q)
            IDLE: begin
                if (scan_en) begin
                    code_d     = ptr_q;
                    cnt_d      = HOLD_LOAD;
                    scan_src_d = 1'b1;
                    state_d    = HOLD;
                end else if (code_valid && code_ready) begin
                    code_d     = code_in;
                    cnt_d      = HOLD_LOAD;
                    scan_src_d = 1'b0;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            GAP: begin
                // Pointer advances even when scan is dropping, so a later session resumes after this code.
                if (scan_src_q) begin
                    ptr_d = ptr_q + 3'd1;
                end
                if (scan_en) begin
                    code_d     = ptr_d;
                    cnt_d      = HOLD_LOAD;
                    scan_src_d = 1'b1;
                    state_d    = HOLD;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they switch on the same edge as the state.
    always_comb begin
        y_d      = '0;
        active_d = 1'b0;
        done_d   = 1'b0;
        if (state_d == HOLD) begin
            y_d      = 8'd1 << code_d;
            active_d = 1'b1;
        end
        if (state_d == GAP) begin
            done_d = 1'b1;
        end
    end

    assign y      = y_q;
    assign active = active_q;
    assign done   = done_q;

endmodule

// File: tb/tb_deco_3a8_seq.sv
// Directed bench: one instance with HOLD_CYCLES=3 (host/back-to-back/reset) and one with
// HOLD_CYCLES=1 (scan sweep, stop/resume).
module tb_deco_3a8_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic [2:0] code3 = '0;
    logic       valid3 = 1'b0;
    logic       scan3 = 1'b0;
    logic       ready3;
    logic [7:0] y3;
    logic       act3, done3;

    logic [2:0] code1 = '0;
    logic       valid1 = 1'b0;
    logic       scan1 = 1'b0;
    logic       ready1;
    logic [7:0] y1;
    logic       act1, done1;

    int unsigned pass_cnt = 0;
    int unsigned total_cnt = 0;
    int unsigned fail_cnt = 0;

    deco_3a8_seq #(.HOLD_CYCLES(3)) dut3 (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code3),
        .code_valid (valid3),
        .code_ready (ready3),
        .scan_en    (scan3),
        .y          (y3),
        .active     (act3),
        .done       (done3)
    );

    deco_3a8_seq #(.HOLD_CYCLES(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code1),
        .code_valid (valid1),
        .code_ready (ready1),
        .scan_en    (scan1),
        .y          (y1),
        .active     (act1),
        .done       (done1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] want);
        total_cnt++;
        assert (obs === want) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic chk3(input string tag, input logic [7:0] wy, input logic wa, input logic wd);
        chk({tag, ".y3"}, y3, wy);
        chk({tag, ".active3"}, {7'd0, act3}, {7'd0, wa});
        chk({tag, ".done3"}, {7'd0, done3}, {7'd0, wd});
    endtask

    task automatic chk1(input string tag, input logic [7:0] wy, input logic wa, input logic wd);
        chk({tag, ".y1"}, y1, wy);
        chk({tag, ".active1"}, {7'd0, act1}, {7'd0, wa});
        chk({tag, ".done1"}, {7'd0, done1}, {7'd0, wd});
    endtask

    task automatic host_code(input logic [2:0] c);
        logic [7:0] want;
        want   = 8'd1 << c;
        code3  = c;
        valid3 = 1'b1;
        #1 chk("host_ready_before", {7'd0, ready3}, 8'd1);
        tick();
        valid3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk3("host_hold", want, 1'b1, 1'b0);
            if (i == 0) chk("host_ready_hold", {7'd0, ready3}, 8'd0);
            tick();
        end
        chk3("host_gap", 8'h00, 1'b0, 1'b1);
        chk("host_ready_gap", {7'd0, ready3}, 8'd0);
        tick();
        chk3("host_idle", 8'h00, 1'b0, 1'b0);
        chk("host_ready_after", {7'd0, ready3}, 8'd1);
    endtask

    initial begin
        logic [7:0] want;

        // Reset and idle
        tick();
        chk3("rst_a", 8'h00, 1'b0, 1'b0);
        chk1("rst_a", 8'h00, 1'b0, 1'b0);
        chk("rst_ready3", {7'd0, ready3}, 8'd0);
        tick();
        chk3("rst_b", 8'h00, 1'b0, 1'b0);
        chk("rst_ready1", {7'd0, ready1}, 8'd0);
        rst = 1'b0;
        #1;
        chk3("post_rst", 8'h00, 1'b0, 1'b0);
        chk("post_rst_ready3", {7'd0, ready3}, 8'd1);
        chk("post_rst_ready1", {7'd0, ready1}, 8'd1);

        // Host decode of code 5 first, then every code
        host_code(3'd5);
        for (int c = 0; c < 8; c++) host_code(3'(c));

        // Back-to-back with valid held high; code_in change during HOLD ignored
        code3  = 3'd2;
        valid3 = 1'b1;
        tick();
        chk3("b2b_h0", 8'h04, 1'b1, 1'b0);
        code3 = 3'd6;
        tick();
        chk3("b2b_h1", 8'h04, 1'b1, 1'b0);
        tick();
        chk3("b2b_h2", 8'h04, 1'b1, 1'b0);
        tick();
        chk3("b2b_gap", 8'h00, 1'b0, 1'b1);
        tick();
        chk3("b2b_idle", 8'h00, 1'b0, 1'b0);
        chk("b2b_idle_ready", {7'd0, ready3}, 8'd1);
        tick();
        valid3 = 1'b0;
        chk3("b2b_6_h0", 8'h40, 1'b1, 1'b0);
        tick();
        chk3("b2b_6_h1", 8'h40, 1'b1, 1'b0);
        tick();
        chk3("b2b_6_h2", 8'h40, 1'b1, 1'b0);
        tick();
        chk3("b2b_6_gap", 8'h00, 1'b0, 1'b1);
        tick();
        chk3("b2b_6_idle", 8'h00, 1'b0, 1'b0);

        // Scan sweep with HOLD_CYCLES=1, showing wrap 7->0
        scan1 = 1'b1;
        #1 chk("scan_ready1", {7'd0, ready1}, 8'd0);
        tick();
        for (int j = 0; j < 20; j++) begin
            if (j % 2 == 0) begin
                want = 8'd1 << ((j / 2) % 8);
                chk1("scan", want, 1'b1, 1'b0);
            end else begin
                chk1("scan_gap", 8'h00, 1'b0, 1'b1);
            end
            tick();
        end

        // Stop during HOLD of code 3, then resume at code 4
        chk1("scan_c2", 8'h04, 1'b1, 1'b0);
        tick();
        chk1("scan_c2_gap", 8'h00, 1'b0, 1'b1);
        tick();
        chk1("scan_c3", 8'h08, 1'b1, 1'b0);
        scan1 = 1'b0;
        tick();
        chk1("stop_gap", 8'h00, 1'b0, 1'b1);
        tick();
        chk1("stop_idle", 8'h00, 1'b0, 1'b0);
        chk("stop_ready1", {7'd0, ready1}, 8'd1);
        tick();
        chk1("stop_idle2", 8'h00, 1'b0, 1'b0);
        scan1 = 1'b1;
        tick();
        chk1("resume_c4", 8'h10, 1'b1, 1'b0);
        scan1 = 1'b0;

        // Scan with HOLD_CYCLES=3, reset in 2nd HOLD cycle of code 7
        scan3 = 1'b1;
        tick();
        for (int n = 0; n < 29; n++) begin
            if (n % 4 == 3) begin
                chk3("scan3_gap", 8'h00, 1'b0, 1'b1);
            end else begin
                want = 8'd1 << (n / 4);
                chk3("scan3", want, 1'b1, 1'b0);
            end
            tick();
        end
        chk3("c7_hold2", 8'h80, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk3("rst_mid", 8'h00, 1'b0, 1'b0);
        chk("rst_mid_ready", {7'd0, ready3}, 8'd0);
        tick();
        chk3("rst_mid_b", 8'h00, 1'b0, 1'b0);
        tick();
        chk3("rst_mid_c", 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
        #1;
        chk3("rel_first", 8'h00, 1'b0, 1'b0);
        chk("rel_ready3", {7'd0, ready3}, 8'd0);
        tick();
        chk3("restart_c0_h0", 8'h01, 1'b1, 1'b0);
        tick();
        chk3("restart_c0_h1", 8'h01, 1'b1, 1'b0);
        tick();
        chk3("restart_c0_h2", 8'h01, 1'b1, 1'b0);
        tick();
        chk3("restart_c0_gap", 8'h00, 1'b0, 1'b1);
        tick();
        chk3("restart_c1", 8'h02, 1'b1, 1'b0);
        scan3 = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
